// File: rtl/elev_pkg.sv
// Shared types and defaults for the elevator SCAN scheduler.
package elev_pkg;
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} elev_state_t;
  localparam int DEF_FLOORS = 8;
endpackage

// File: rtl/elev_dir_prio_enc.sv
// Direction-split priority encoder: nearest pending floor above and below cur.
module elev_dir_prio_enc #(
  parameter  int FLOORS = 8,
  localparam int FW     = $clog2(FLOORS)
) (
  input  logic [FLOORS-1:0] req,
  input  logic [FW-1:0]     cur,
  output logic [FW-1:0]     above,
  output logic              above_vld,
  output logic [FW-1:0]     below,
  output logic              below_vld
);
  // Later assignments win: the downward sweep leaves the lowest bit above cur,
  // the upward sweep leaves the highest bit below cur.
  always_comb begin
    above     = '0;
    above_vld = 1'b0;
    below     = '0;
    below_vld = 1'b0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (req[i] && (FW'(i) > cur)) begin
        above     = FW'(i);
        above_vld = 1'b1;
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (req[i] && (FW'(i) < cur)) begin
        below     = FW'(i);
        below_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/elev_scan_scheduler.sv
// Elevator SCAN scheduler: latches calls, picks the next stop, sequences motion and door.
// Optional emergency-descent mode enabled by defining ELEV_EMERGENCY_EN.
module elev_scan_scheduler import elev_pkg::*; #(
  parameter  int FLOORS      = DEF_FLOORS,
  parameter  int MOVE_CYCLES = 8,
  parameter  int DOOR_CYCLES = 4,
  localparam int FW          = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ELEV_EMERGENCY_EN
  input  logic              emerg_i,
`endif
  input  logic [FLOORS-1:0] req_i,
  output logic [FLOORS-1:0] pending_o,
  output logic [FW-1:0]     cur_floor_o,
  output logic [FW-1:0]     target_o,
  output logic              target_valid_o,
  output logic              dir_up_o,
  output logic              moving_o,
  output logic              door_open_o
);
  localparam int CMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(FLOORS - 1);

  elev_state_t       state, state_n;
  logic [FW-1:0]     cur, cur_n;
  logic              dir, dir_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [FLOORS-1:0] pend, pend_n;
  logic [FLOORS-1:0] here_mask;
  logic [FW-1:0]     above, below, step_floor;
  logic              above_vld, below_vld, arrive;
`ifdef ELEV_EMERGENCY_EN
  logic              emerg_q;
`endif

  elev_dir_prio_enc #(.FLOORS(FLOORS)) u_enc (
    .req       (pend),
    .cur       (cur),
    .above     (above),
    .above_vld (above_vld),
    .below     (below),
    .below_vld (below_vld)
  );

  always_comb begin
    target_valid_o = |pend;
    if (!(|pend))                     target_o = cur;
    else if (state == IDLE && pend[cur]) target_o = cur;
    else if (dir)                     target_o = above_vld ? above : (below_vld ? below : cur);
    else                              target_o = below_vld ? below : (above_vld ? above : cur);
`ifdef ELEV_EMERGENCY_EN
    if (emerg_i) target_o = '0;
`endif
  end

  assign arrive     = (cnt == CW'(MOVE_CYCLES - 1));
  assign step_floor = dir ? (cur + FW'(1)) : (cur - FW'(1));

  always_comb begin
    state_n        = state;
    cur_n          = cur;
    dir_n          = dir;
    cnt_n          = cnt;
    here_mask      = '0;
    here_mask[cur] = 1'b1;
    // Door-cycle clear is applied after the set so it wins on a same-floor re-request.
    pend_n = pend | req_i;
    if (state == DOOR) pend_n = pend_n & ~here_mask;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (pend[cur]) state_n = DOOR;
        else if (dir ? above_vld : below_vld) state_n = MOVE;
        else if (dir ? below_vld : above_vld) begin
          dir_n   = ~dir;
          state_n = MOVE;
        end
      end
      MOVE: begin
        if (arrive) begin
          cnt_n = '0;
          cur_n = step_floor;
          if (step_floor == TOP_FLOOR) dir_n = 1'b0;
          else if (step_floor == '0)   dir_n = 1'b1;
          if (pend[step_floor]) state_n = DOOR;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DOOR: begin
        if (cnt == CW'(DOOR_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef ELEV_EMERGENCY_EN
    // Emergency: descend without stopping, hold door open at floor 0.
    if (emerg_i) begin
      pend_n  = '0;
      dir_n   = 1'b0;
      state_n = MOVE;
      cur_n   = cur;
      if (state == MOVE && !dir && cur != '0) begin
        cnt_n = arrive ? '0 : cnt + CW'(1);
        if (arrive) cur_n = cur - FW'(1);
      end else begin
        cnt_n = '0;
      end
      if (cur_n == '0) begin
        state_n = DOOR;
        cnt_n   = '0;
        dir_n   = 1'b1;
      end
    end else if (emerg_q) begin
      state_n = IDLE;
      cnt_n   = '0;
      cur_n   = cur;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur   <= '0;
      dir   <= 1'b1;
      cnt   <= '0;
      pend  <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      dir   <= dir_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
    end
  end

`ifdef ELEV_EMERGENCY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) emerg_q <= 1'b0;
    else        emerg_q <= emerg_i;
  end
`endif

  assign pending_o   = pend;
  assign cur_floor_o = cur;
  assign dir_up_o    = dir;
  assign moving_o    = (state == MOVE);
  assign door_open_o = (state == DOOR);
endmodule

// File: tb/tb_elev_scan_scheduler.sv
// Bench for elev_scan_scheduler: directed scenarios plus random calls against a floor-level model.
module tb_elev_scan_scheduler;
  localparam int F = 8, MC = 8, DC = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] pend;
  logic [2:0] cur, tgt;
  logic       tvld, dir, mov, door;
  logic [5:0] req6 = '0;
  logic [5:0] pend6;
  logic [2:0] cur6, tgt6;
  logic       tvld6, dir6, mov6, door6;
`ifdef ELEV_EMERGENCY_EN
  logic       emerg = 1'b0;
`endif

  elev_scan_scheduler #(.FLOORS(F), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ELEV_EMERGENCY_EN
    .emerg_i(emerg),
`endif
    .req_i(req), .pending_o(pend), .cur_floor_o(cur), .target_o(tgt),
    .target_valid_o(tvld), .dir_up_o(dir), .moving_o(mov), .door_open_o(door)
  );

  elev_scan_scheduler #(.FLOORS(6), .MOVE_CYCLES(2), .DOOR_CYCLES(2)) dut6 (
    .clk(clk), .rst_n(rst_n),
`ifdef ELEV_EMERGENCY_EN
    .emerg_i(emerg),
`endif
    .req_i(req6), .pending_o(pend6), .cur_floor_o(cur6), .target_o(tgt6),
    .target_valid_o(tvld6), .dir_up_o(dir6), .moving_o(mov6), .door_open_o(door6)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Model: phase 0 = idle, 1 = travelling, 2 = door open; m_t counts elapsed cycles.
  bit [7:0] m_pend;
  int       m_floor, m_ph, m_t;
  bit       m_dir;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic bit any_side(input bit up);
    for (int f = 0; f < F; f++)
      if (m_pend[f] && (up ? (f > m_floor) : (f < m_floor))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_target();
    int f;
    if (m_pend == 0) return m_floor;
    if (m_ph == 0 && m_pend[m_floor]) return m_floor;
    for (int d = 1; d < F; d++) begin
      f = m_dir ? m_floor + d : m_floor - d;
      if (f >= 0 && f < F && m_pend[f]) return f;
    end
    for (int d = 1; d < F; d++) begin
      f = m_dir ? m_floor - d : m_floor + d;
      if (f >= 0 && f < F && m_pend[f]) return f;
    end
    return m_floor;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_floor = 0; m_dir = 1'b1; m_ph = 0; m_t = 0;
  endtask

  task automatic model_step(input bit [7:0] r);
    bit [7:0] np;
    np = m_pend | r;
    case (m_ph)
      0: begin
        m_t = 0;
        if (m_pend[m_floor]) m_ph = 2;
        else if (any_side(m_dir)) m_ph = 1;
        else if (any_side(!m_dir)) begin m_dir = !m_dir; m_ph = 1; end
      end
      1: begin
        m_t++;
        if (m_t == MC) begin
          m_t = 0;
          m_floor += m_dir ? 1 : -1;
          if (m_floor == F - 1) m_dir = 1'b0;
          if (m_floor == 0) m_dir = 1'b1;
          if (m_pend[m_floor]) m_ph = 2;
        end
      end
      default: begin
        np[m_floor] = 1'b0;
        m_t++;
        if (m_t == DC) begin m_ph = 0; m_t = 0; end
      end
    endcase
    m_pend = np;
  endtask

  task automatic check_all();
    chk("pending", pend, m_pend);
    chk("cur_floor", cur, m_floor);
    chk("target", tgt, exp_target());
    chk("target_valid", tvld, m_pend != 0);
    chk("dir_up", dir, m_dir);
    chk("moving", mov, m_ph == 1);
    chk("door_open", door, m_ph == 2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(req);
    #1;
    check_all();
  endtask

  task automatic pulse(input logic [7:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int k, cnt_door, cnt_mov;
    int stops[$];
    bit prev_door;

    // Reset state
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Call at the current floor: door opens and dwells DC cycles
    pulse(8'h01);
    chk("latch_latency", pend, 8'h01);
    cnt_door = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (door) cnt_door++;
    end
    chk("door_dwell", cnt_door, DC);
    chk("call_cleared", pend, 8'h00);

    // Single trip to floor 5
    pulse(8'h20);
    cnt_mov = 0;
    k = 0;
    while (!door && k < 100) begin
      tick();
      if (mov) cnt_mov++;
      k++;
    end
    chk("trip_timeout", k < 100, 1);
    chk("trip_floor", cur, 5);
    chk("trip_move_cycles", cnt_mov, 5 * MC);
    chk("trip_door_not_moving", mov, 0);
    for (int i = 0; i < DC + 2; i++) tick();

    // SCAN ordering: heading up past 3 towards 6, add calls at 1 and 4
    do_reset();
    pulse(8'h40);
    k = 0;
    while (cur != 3 && k < 100) begin tick(); k++; end
    chk("scan_reach3_timeout", k < 100, 1);
    pulse(8'h12);
    prev_door = 1'b0;
    k = 0;
    while (stops.size() < 3 && k < 400) begin
      tick();
      if (door && !prev_door) stops.push_back(int'(cur));
      prev_door = door;
      k++;
    end
    chk("scan_stop_count", stops.size(), 3);
    if (stops.size() == 3) begin
      chk("scan_stop0", stops[0], 4);
      chk("scan_stop1", stops[1], 6);
      chk("scan_stop2", stops[2], 1);
    end
    for (int i = 0; i < DC + 2; i++) tick();

    // Asynchronous reset mid-move
    pulse(8'h80);
    for (int i = 0; i < 20; i++) tick();
    chk("pre_reset_moving", mov, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Random calls, then drain
    for (int i = 0; i < 1500; i++) begin
      req = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      tick();
    end
    req = '0;
    for (int i = 0; i < 400; i++) tick();
    chk("drain_empty", pend, 8'h00);

    // Six-floor instance: top floor forces direction down
    do_reset();
    chk("f6_reset_floor", cur6, 0);
    chk("f6_reset_dir", dir6, 1);
    req6 = 6'h20;
    tick();
    req6 = '0;
    k = 0;
    while (!door6 && k < 200) begin tick(); k++; end
    chk("f6_timeout", k < 200, 1);
    chk("f6_floor", cur6, 5);
    chk("f6_dir_down", dir6, 0);
    chk("f6_not_moving", mov6, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("f6_pending_clear", pend6, 6'h00);
    chk("f6_target_idle", tgt6, 5);
    chk("f6_target_valid", tvld6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/elev_scan_scheduler.md
Name: elev_scan_scheduler

Overview:
- Parametrised successor to the elevator's 8:3 floor priority encoder.
- Latches floor call requests and tracks the car's current floor.
- Selects the next target floor using direction-aware SCAN scheduling, not fixed highest-floor priority.
- Sequences car motion and door dwell; sits between the call-button inputs and the motor/door actuator interface.

Parameters:
- FLOORS, 8: number of floors. Range 2..64; need not be a power of 2.
- MOVE_CYCLES, 8: clock cycles of travel per floor. Must be ≥1.
- DOOR_CYCLES, 4: clock cycles the door stays open. Must be ≥1.
- Localparam FW = $clog2(FLOORS): floor index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  FLOORS  floor call requests; bit i = call at floor i; level or pulse, sampled every cycle.
- pending_o  out  FLOORS  latched outstanding requests.
- cur_floor_o  out  FW  current car floor.
- target_o  out  FW  next floor the car will stop at.
- target_valid_o  out  1  high when any request is pending.
- dir_up_o  out  1  scan direction: 1 = up, 0 = down.
- moving_o  out  1  car travelling between floors.
- door_open_o  out  1  door open.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: pending=0, cur_floor=0, state=IDLE, dir_up=1, moving=0, door_open=0, target=0, target_valid=0.
- Reset asserted mid-move or with the door open aborts immediately to these values.
- Request latching:
  - pending[i] <= pending[i] | req_i[i], one-cycle latency.
  - pending[cur_floor] is cleared on every cycle in DOOR. A clear wins over a simultaneous set for the same bit.
- Direction-aware target (combinational from registered state):
  - above = nearest pending floor > cur; below = nearest pending floor < cur.
  - If dir_up: target = above if it exists, else below. If not dir_up: the mirror.
  - If pending[cur] is set in IDLE: target = cur.
  - With no pending requests: target=cur_floor and target_valid=0. The output is never X.
- States:
  - IDLE:
    - pending[cur] → DOOR.
    - Else a request in the current direction → MOVE.
    - Else a request in the opposite direction → flip dir_up, then MOVE.
    - Else stay in IDLE.
  - MOVE:
    - moving=1. A counter runs 0..MOVE_CYCLES-1.
    - At the terminal count, cur_floor ±1 per dir_up.
    - If pending[new floor] is set → DOOR. Else continue MOVE. A new floor stop is decided at arrival.
  - DOOR:
    - door_open=1 for exactly DOOR_CYCLES cycles, then → IDLE.
    - A re-request for the current floor during DOOR is absorbed.
- Boundaries:
  - cur_floor never exceeds FLOORS-1 and never goes below 0.
  - At FLOORS-1, dir_up is forced to 0 on arrival. At floor 0, dir_up is forced to 1.
  - req_i bits change freely during MOVE. A request for a floor already passed is served after reversal.
- Latency: request at the current floor in IDLE, sampled at edge N → pending at N+1 → door_open at N+2.

Optional Feature:
- Macro: ELEV_EMERGENCY_EN.
- When defined, the block adds port emerg_i (in, 1). While emerg_i=1:
  - pending is cleared and req_i is ignored.
  - target=0; the car travels down and skips all stops.
  - At floor 0 the door opens and stays open while emerg_i=1.
- On deassert, the car returns to IDLE with empty pending.
- When not defined, the port and the logic are absent.

Decomposition:
- Package elev_pkg holds:
  - the typedef enum logic [1:0] elev_state_t {IDLE, MOVE, DOOR};
  - a default FLOORS constant.
- Sub-module elev_dir_prio_enc: parametrised by FLOORS.
  - Inputs: req vector, cur floor.
  - Outputs: above index and valid, below index and valid.
  - Each is a masked priority encode: lowest set bit above cur, highest set bit below cur.

Test Plan:
- Reset: after rst_n release, all outputs are 0 and dir_up_o=1. Asserting rst_n low mid-MOVE returns all outputs to reset values asynchronously.
- Current-floor call: idle at 0, req_i=8'h01 for one cycle → pending_o=01 next cycle → door_open_o high for 4 cycles → pending_o=0, IDLE.
- Single trip: idle at 0, req_i=8'h20.
  - cur_floor_o steps 1..5, one step every 8 cycles.
  - target_o=5 throughout; door opens at floor 5; moving_o is low during DOOR.
- SCAN ordering: at floor 3 going up with pending {6}, pulse req for floors 1 and 4 → stops at 4, then 6; then dir_up_o=0 and the car travels to 1.
- Non-power-of-2 top: FLOORS=6, req floor 5 → the car reaches 5 and dir_up_o=0; a request above FLOORS-1 cannot be expressed.
- ELEV_EMERGENCY_EN: at floor 4 with pending {6}, raise emerg_i → pending_o=0, the car descends to 0 without stopping, door_open_o stays 1 until emerg_i drops.
